// File: rtl/aes_pkg.sv
// Shared AES definitions: constants, the xtime helper, the column<->word byte layout helpers
// and the key-expansion FSM state type.
package aes_pkg;

  localparam logic [3:0] AES_NR    = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } fsm_state_t;

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c of the state as a FIPS word: bytes c, c+4, c+8, c+12, MSB first.
  function automatic logic [31:0] state_word(input logic [127:0] s, input int c);
    logic [127:0] t;
    t = s << (8 * c);
    return {t[127:120], t[95:88], t[63:56], t[31:24]};
  endfunction

  // Re-pack four FIPS words into the row-major state layout.
  function automatic logic [127:0] words_to_state(input logic [31:0] w0, input logic [31:0] w1,
                                                  input logic [31:0] w2, input logic [31:0] w3);
    return {w0[31:24], w1[31:24], w2[31:24], w3[31:24],
            w0[23:16], w1[23:16], w2[23:16], w3[23:16],
            w0[15:8],  w1[15:8],  w2[15:8],  w3[15:8],
            w0[7:0],   w1[7:0],   w2[7:0],   w3[7:0]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, organised as 16 rows of 16 bytes selected by the high nibble.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [127:0] row;
  logic [127:0] shifted;

  // Row lookup on the high nibble; the low nibble then selects the byte within the row.
  always_comb begin
    row = 128'h0;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = 128'h0;
    endcase
    shifted = row << {a[3:0], 3'b000};
    y = shifted[127:120];
  end

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10 one per clock and stores them in
// an 11-entry table with a combinational read port for the round stage.
module aes128_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  fsm_state_t   state;
  fsm_state_t   next_state;
  logic [127:0] work;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [127:0] key_table [0:10];

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign w0 = state_word(work, 0);
  assign w1 = state_word(work, 1);
  assign w2 = state_word(work, 2);
  assign w3 = state_word(work, 3);

  assign rot = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .a (rot[8*gi +: 8]),
        .y (sub[8*gi +: 8])
      );
    end
  endgenerate

  assign temp     = sub ^ {rcon, 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = words_to_state(n0, n1, n2, n3);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start is only honoured from IDLE, so it is ignored on the done cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = EXPAND;
        end else begin
          next_state = IDLE;
        end
      end
      EXPAND: begin
        if (rnd == AES_NR) begin
          next_state = IDLE;
        end else begin
          next_state = EXPAND;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state and round registers.
  always_comb begin
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        done     = 1'b0;
      end
      EXPAND: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        done     = (rnd == AES_NR);
      end
      default: begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        done     = 1'b0;
      end
    endcase
  end

  // The working key and round index are the stream; they hold after round 10.
  assign rk_out   = work;
  assign rk_round = rnd;

  // Working key, round counter and rcon; the key computed during round 10 is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= 128'h0;
      rnd  <= 4'd0;
      rcon <= RCON_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= key_in;
            rnd  <= 4'd0;
            rcon <= RCON_INIT;
          end
        end
        EXPAND: begin
          if (rnd != AES_NR) begin
            work <= next_key;
            rnd  <= rnd + 4'd1;
            rcon <= xtime(rcon);
          end
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

  // Round-key table: entry rnd is written at the end of the cycle that streams it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        key_table[i] <= 128'h0;
      end
    end else if (state == EXPAND) begin
      key_table[rnd] <= work;
    end
  end

  assign rd_key = (rd_addr > AES_NR) ? 128'h0 : key_table[rd_addr];

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand: vector table plus hand-written corner sequences,
// checked against an independent key-schedule model (S-box derived from GF(2^8) inversion).
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m    [0:255];
  logic [127:0] exp_keys  [0:10];
  logic [127:0] got       [0:10];
  logic [127:0] tbl_model [0:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
    bit           hand;
  } vec_t;

  vec_t vecs [0:3];

  aes128_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int yv = 1; yv < 256; yv++) begin
        if (gmul(8'(x), 8'(yv)) == 8'h01) inv = 8'(yv);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] st;
    for (int c = 0; c < 4; c++) begin
      w[c] = {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      st = 128'h0;
      for (int k = 0; k < 16; k++) begin
        st[127-8*k -: 8] = w[4*r + k%4][31-8*(k/4) -: 8];
      end
      exp_keys[r] = st;
    end
  endtask

  // Checks the 11 stream cycles after start was accepted at the previous edge.
  task automatic stream(input logic [127:0] key, input bit mid_start, input bit done_start,
                        input logic [127:0] next_key);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0 || i == 4) start = 1'b0;
      check($sformatf("rk_valid r%0d", i), rk_valid, 1);
      check($sformatf("busy r%0d", i), busy, 1);
      check($sformatf("rk_round r%0d", i), rk_round, i);
      check($sformatf("rk_out r%0d", i), rk_out, exp_keys[i]);
      check($sformatf("done r%0d", i), done, (i == 10) ? 1 : 0);
      got[i] = rk_out;
      rd_addr = 4'(i);
      #1 check($sformatf("rd_key old entry %0d", i), rd_key, tbl_model[i]);
      tbl_model[i] = exp_keys[i];
      if (i > 0) begin
        rd_addr = 4'(i - 1);
        #1 check($sformatf("rd_key new entry %0d", i - 1), rd_key, tbl_model[i-1]);
      end
      if (mid_start && i == 3) begin
        start  = 1'b1;
        key_in = ~key;
      end
      if (done_start && i == 10) begin
        start  = 1'b1;
        key_in = next_key;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " busy low"}, busy, 0);
    check({tag, " rk_valid low"}, rk_valid, 0);
    check({tag, " done low"}, done, 0);
    check({tag, " rk_round hold"}, rk_round, 10);
    check({tag, " rk_out hold"}, rk_out, exp_keys[10]);
  endtask

  task automatic sweep_table(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1 check($sformatf("%s rd_key[%0d]", tag, a), rd_key, (a <= 10) ? tbl_model[a] : 128'h0);
    end
  endtask

  task automatic kick(input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    compute_model(key);
  endtask

  initial begin
    vecs[0] = '{128'h2b28ab097eaef7cf15d2154f16a6883c, 128'ha088232afa54a36cfe2c397617b13905,
                128'hd0c9e1b614ee3f63f9250c0ca889c8a6, 1'b1};
    vecs[1] = '{128'h0, 128'h62626262636363636363636363636363,
                128'hb43e236fef92e98f5be25118cb11cf8e, 1'b1};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h0, 1'b0};
    vecs[3] = '{128'hffffffffffffffff0123456789abcdef, 128'h0, 128'h0, 1'b0};

    rst = 1'b0; start = 1'b0; key_in = 128'h0; rd_addr = 4'd0;
    for (int i = 0; i < 11; i++) tbl_model[i] = 128'h0;
    build_sbox();
    exp_keys[10] = 128'h0;

    #2 rst = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset rk_valid", rk_valid, 0);
    check("reset done", done, 0);
    check("reset rk_round", rk_round, 0);
    check("reset rk_out", rk_out, 0);
    sweep_table("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      kick(vecs[v].key);
      stream(vecs[v].key, 1'b0, 1'b0, 128'h0);
      idle_check($sformatf("vec%0d", v));
      check($sformatf("vec%0d round0 equals key", v), got[0], vecs[v].key);
      if (vecs[v].hand) begin
        check($sformatf("vec%0d round1 hand", v), got[1], vecs[v].r1);
        check($sformatf("vec%0d round10 hand", v), got[10], vecs[v].r10);
      end
      if (v == 0) sweep_table("fips readback");
    end

    // Start while busy and on the done cycle; the latter is held so it is taken at T+12.
    kick(vecs[0].key);
    stream(vecs[0].key, 1'b1, 1'b1, vecs[1].key);
    idle_check("busy-start");
    compute_model(vecs[1].key);
    stream(vecs[1].key, 1'b0, 1'b0, 128'h0);
    idle_check("restart after done");
    check("restart round1", got[1], vecs[1].r1);

    // Reset in the cycle carrying round 5 (T+6).
    kick(vecs[2].key);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset rk_valid", rk_valid, 0);
    check("midreset done", done, 0);
    check("midreset rk_round", rk_round, 0);
    check("midreset rk_out", rk_out, 0);
    for (int i = 0; i < 11; i++) tbl_model[i] = 128'h0;
    sweep_table("midreset");
    @(negedge clk);
    rst = 1'b0;
    kick(vecs[0].key);
    stream(vecs[0].key, 1'b0, 1'b0, 128'h0);
    idle_check("after reset");
    check("after reset round1", got[1], vecs[0].r1);
    check("after reset round10", got[10], vecs[0].r10);
    sweep_table("after reset readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
